// File: rtl/spi_tx_scheduler_pkg.sv
// Shared definitions for the SPI transmit scheduler: FSM state encoding and default word width.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_START  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/spi_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  int unsigned k;
  logic        found;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    k          = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found         = 1'b1;
        win_onehot[k] = 1'b1;
        win_idx       = IDX_W'(k);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Shares one SPI master among NUM_REQ requesters: round-robin grant, word latch, start/busy handshake.
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                      CLOCK_50,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err_timeout,
  output logic                      spi_start_n,
  output logic [DATA_W-1:0]         spi_data,
  input  logic                      spi_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (arb_onehot),
    .win_idx    (arb_idx),
    .any_req    (arb_any)
  );

  assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (arb_any && !spi_busy) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_START;
      ST_START: begin
        if (spi_busy)         state_d = ST_ACTIVE;
        else if (timeout_hit) state_d = ST_FINISH;
      end
      ST_ACTIVE: if (!spi_busy) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // done/err_timeout are registered on FINISH entry so they are high during the FINISH cycle.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      done        <= '0;
      err_timeout <= 1'b0;
      spi_start_n <= 1'b1;
      spi_data    <= '0;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      timer_q     <= '0;
    end else begin
      done        <= '0;
      err_timeout <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (state_d == ST_SETUP) begin
            spi_data <= req_data[arb_idx*DATA_W +: DATA_W];
            grant    <= arb_onehot;
            win_q    <= arb_idx;
          end
        end
        ST_SETUP: begin
          spi_start_n <= 1'b0;
          timer_q     <= '0;
        end
        ST_START: begin
          if (spi_busy) begin
            spi_start_n <= 1'b1;
          end else if (timeout_hit) begin
            spi_start_n <= 1'b1;
            err_timeout <= 1'b1;
            done        <= grant;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!spi_busy) done <= grant;
        end
        ST_FINISH: begin
          grant    <= '0;
          rr_ptr_q <= (32'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler with a simple spi_master busy model.
module tb_spi_tx_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 64;

  logic             CLOCK_50 = 1'b0;
  logic             rst_n    = 1'b0;
  logic [NR-1:0]    req      = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    grant, done;
  logic             err_timeout, spi_start_n, spi_busy;
  logic [DW-1:0]    spi_data;

  logic        model_en   = 1'b1;
  logic        force_busy = 1'b0;
  logic        mbusy;
  int unsigned mcnt;
  int unsigned busy_len = 40;

  int vectors     = 0;
  int miscompares = 0;
  int viol        = 0;
  logic prev_start_n = 1'b1;

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] grant;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tbl[10];

  always #10 CLOCK_50 = ~CLOCK_50;

  spi_tx_scheduler #(
    .NUM_REQ     (NR),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .err_timeout (err_timeout),
    .spi_start_n (spi_start_n),
    .spi_data    (spi_data),
    .spi_busy    (spi_busy)
  );

  assign spi_busy = mbusy | force_busy;

  // Master model: busy is high from the second cycle of start_n low, for busy_len cycles.
  always @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
    end else if (!mbusy) begin
      if (model_en && !spi_start_n) begin
        mbusy <= 1'b1;
        mcnt  <= 0;
      end
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt == busy_len - 1) mbusy <= 1'b0;
    end
  end

  always @(negedge CLOCK_50) begin
    if (rst_n) begin
      if ($countones(grant) > 1 || $countones(done) > 1) viol++;
      if (prev_start_n && !spi_start_n && spi_busy) viol++;
    end
    prev_start_n = spi_start_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name, input logic [NR-1:0] exp);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      if (grant != '0) break;
    end
    chk({name, "_grant"}, 32'(grant), 32'(exp));
  endtask

  task automatic wait_done(input string name, input logic [NR-1:0] exp);
    for (int i = 0; i < 400; i++) begin
      @(negedge CLOCK_50);
      if (done != '0) break;
    end
    chk({name, "_done"}, 32'(done), 32'(exp));
  endtask

  task automatic run_xfer(input string name, input logic [NR-1:0] exp_g, input logic [DW-1:0] exp_d);
    wait_grant(name, exp_g);
    chk({name, "_data"}, 32'(spi_data), 32'(exp_d));
    chk({name, "_setup_start_n"}, 32'(spi_start_n), 32'd1);
    wait_done(name, exp_g);
    chk({name, "_grant_at_done"}, 32'(grant), 32'(exp_g));
  endtask

  initial begin
    int n;

    tbl[0] = '{4'b1111, 4'b0001, 16'h1111};
    tbl[1] = '{4'b1111, 4'b0010, 16'h2222};
    tbl[2] = '{4'b1111, 4'b0100, 16'h3333};
    tbl[3] = '{4'b1111, 4'b1000, 16'h4444};
    tbl[4] = '{4'b1111, 4'b0001, 16'h1111};
    tbl[5] = '{4'b1010, 4'b0010, 16'h2222};
    tbl[6] = '{4'b1010, 4'b1000, 16'h4444};
    tbl[7] = '{4'b0110, 4'b0010, 16'h2222};
    tbl[8] = '{4'b0001, 4'b0001, 16'h1111};
    tbl[9] = '{4'b1101, 4'b0100, 16'h3333};

    // Reset state
    tick(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_start_n", 32'(spi_start_n), 32'd1);
    chk("rst_data", 32'(spi_data), 32'd0);
    rst_n = 1'b1;

    // Single request, exact latencies
    req_data[0 +: DW] = 16'hDEAD;
    req = 4'b0001;
    tick(1);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_data", 32'(spi_data), 32'hDEAD);
    chk("t1_setup_start_n", 32'(spi_start_n), 32'd1);
    tick(1);
    chk("t1_start_n_c0", 32'(spi_start_n), 32'd0);
    tick(1);
    chk("t1_start_n_c1", 32'(spi_start_n), 32'd0);
    tick(1);
    chk("t1_start_n_rel", 32'(spi_start_n), 32'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (!spi_busy) break;
    end
    chk("t1_busy_fell", 32'(spi_busy), 32'd0);
    chk("t1_done_early", 32'(done), 32'd0);
    tick(1);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_grant_at_done", 32'(grant), 32'h1);
    req = '0;
    tick(1);
    chk("t1_done_cleared", 32'(done), 32'd0);
    chk("t1_grant_cleared", 32'(grant), 32'd0);

    // Round-robin table
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      run_xfer($sformatf("rr%0d", i), tbl[i].grant, tbl[i].data);
    end
    req = '0;

    // Start timeout: master never answers
    do_reset();
    model_en = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 10 && spi_start_n; i++) @(negedge CLOCK_50);
    n = 0;
    while (!spi_start_n && n < 200) begin
      n++;
      @(negedge CLOCK_50);
    end
    chk("t3_low_cycles", 32'(n), 32'(TO));
    chk("t3_err", 32'(err_timeout), 32'd1);
    chk("t3_done", 32'(done), 32'h1);
    tick(1);
    chk("t3_err_cleared", 32'(err_timeout), 32'd0);
    model_en = 1'b1;
    run_xfer("t3_next", 4'b0001, 16'h1111);
    req = '0;

    // Drop request and change its word mid-transfer
    do_reset();
    req = 4'b0010;
    wait_grant("t4", 4'b0010);
    tick(10);
    req = '0;
    req_data[DW +: DW] = 16'hBEEF;
    tick(1);
    chk("t4_data_held", 32'(spi_data), 32'h2222);
    wait_done("t4", 4'b0010);
    req = 4'b1111;
    run_xfer("t4_rr_ptr", 4'b0100, 16'h3333);

    // Asynchronous reset mid-transfer
    req = 4'b0100;
    wait_grant("t5", 4'b0100);
    tick(10);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_start_n", 32'(spi_start_n), 32'd1);
    chk("t5_data", 32'(spi_data), 32'd0);
    tick(3);
    rst_n = 1'b1;
    req_data[DW +: DW] = 16'h2222;
    req = 4'b1111;
    run_xfer("t5_restart", 4'b0001, 16'h1111);

    // Master busy at idle blocks arbitration
    req = '0;
    force_busy = 1'b1;
    tick(1);
    req = 4'b0100;
    tick(8);
    chk("t6_no_grant", 32'(grant), 32'd0);
    chk("t6_start_n", 32'(spi_start_n), 32'd1);
    force_busy = 1'b0;
    tick(1);
    chk("t6_grant", 32'(grant), 32'h4);
    wait_done("t6", 4'b0100);
    req = '0;
    tick(2);

    chk("invariants", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
